clb_bist: RTL and testbench

Built-in self-test controller for the configurable logic block (CLB). On a start request it drives all 16 combinations of the CLB's 2-bit function select and 2-bit data operands onto the CLB inputs, samples the CLB output after a programmable settle time, and compares each sample against the golden truth table. Results are reported as a pass flag, a mismatch count and a per-vector failure mask. It sits beside the CLB: its stimulus outputs feed the CLB pad inputs `[3:0]`, and the CLB output bit 0 feeds back into it.

---
 rtl/clb_bist.sv | 103 ++++++++++
 tb/tb_clb_bist.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_bist.sv
// BIST for the CLB: walks all 16 {sel,a,b} vectors and checks each against the golden truth table.
// Latency: 16*(SETTLE_CYCLES+1) cycles from the start edge to done; each vector is held SETTLE_CYCLES+1 cycles.
// Backpressure: none; start is ignored while a run is in progress.
module clb_bist #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic [3:0]  clb_in_o,
    input  logic        clb_out_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [4:0]  err_count_o,
    output logic [15:0] fail_vec_o
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    localparam logic [3:0]  SETTLE      = 4'(SETTLE_CYCLES);
    // Vectors whose golden result is 1: AND@3, OR@5..7, XOR@9,10.
    localparam logic [15:0] GOLDEN_MASK = 16'h06E8;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  vec;
    logic [3:0]  vec_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [4:0]  err_cnt;
    logic [4:0]  err_cnt_nxt;
    logic [15:0] fail_vec;
    logic [15:0] fail_vec_nxt;
    logic        mismatch;

    // Case inequality so an unresolved CLB output is reported as a failure.
    assign mismatch = (clb_out_i !== GOLDEN_MASK[vec]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            vec      <= 4'd0;
            cnt      <= 4'd0;
            err_cnt  <= 5'd0;
            fail_vec <= 16'd0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            cnt      <= cnt_nxt;
            err_cnt  <= err_cnt_nxt;
            fail_vec <= fail_vec_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        vec_nxt      = vec;
        cnt_nxt      = cnt;
        err_cnt_nxt  = err_cnt;
        fail_vec_nxt = fail_vec;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    state_nxt    = DRIVE;
                    vec_nxt      = 4'd0;
                    cnt_nxt      = SETTLE;
                    err_cnt_nxt  = 5'd0;
                    fail_vec_nxt = 16'd0;
                end
            end
            DRIVE: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    if (mismatch) begin
                        err_cnt_nxt       = err_cnt + 5'd1;
                        fail_vec_nxt[vec] = 1'b1;
                    end
                    if (vec == 4'd15) begin
                        state_nxt = DONE;
                    end else begin
                        vec_nxt = vec + 4'd1;
                        cnt_nxt = SETTLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clb_in_o    = vec;
    assign busy_o      = (state == DRIVE);
    assign done_o      = (state == DONE);
    assign pass_o      = (state == DONE) && (err_cnt == 5'd0);
    assign err_count_o = err_cnt;
    assign fail_vec_o  = fail_vec;

endmodule

// File: tb/tb_clb_bist.sv
// Bench for clb_bist: a behavioural CLB with selectable faults drives two DUTs (S=1 and S=3);
// results are compared against masks derived from the truth-table rules.
module tb_clb_bist;

    localparam int M_IDEAL = 0;
    localparam int M_SA0   = 1;
    localparam int M_SA1   = 2;
    localparam int M_XNOR  = 3;
    localparam int M_INJ   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start3;
    logic [3:0]  in1, in3;
    logic        out1, out3;
    logic        busy1, busy3, done1, done3, pass1, pass3;
    logic [4:0]  err1, err3;
    logic [15:0] fail1, fail3;
    int          mode1, mode3;
    logic [15:0] inj1, inj3;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    function automatic logic golden(input logic [3:0] k);
        logic a, b;
        a = k[1];
        b = k[0];
        case (k[3:2])
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic clb_model(input int mode, input logic [3:0] k, input logic [15:0] inj);
        case (mode)
            M_SA0:   return 1'b0;
            M_SA1:   return 1'b1;
            M_XNOR:  return (k[3:2] == 2'b10) ? ~(k[1] ^ k[0]) : golden(k);
            M_INJ:   return golden(k) ^ inj[k];
            default: return golden(k);
        endcase
    endfunction

    function automatic logic [15:0] exp_mask(input int mode, input logic [15:0] inj);
        logic [15:0] m;
        m = 16'd0;
        for (int k = 0; k < 16; k++)
            if (clb_model(mode, 4'(k), inj) !== golden(4'(k))) m[k] = 1'b1;
        return m;
    endfunction

    function automatic int popcount(input logic [15:0] m);
        int c;
        c = 0;
        for (int i = 0; i < 16; i++) c += int'(m[i]);
        return c;
    endfunction

    assign out1 = clb_model(mode1, in1, inj1);
    assign out3 = clb_model(mode3, in3, inj3);

    clb_bist #(.SETTLE_CYCLES(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .clb_in_o(in1), .clb_out_i(out1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1), .fail_vec_o(fail1)
    );

    clb_bist #(.SETTLE_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .clb_in_o(in3), .clb_out_i(out3),
        .busy_o(busy3), .done_o(done3), .pass_o(pass3), .err_count_o(err3), .fail_vec_o(fail3)
    );

    // Pulses start, then counts busy cycles and checks clb_in walks 0..15 holding each S+1 cycles.
    // poke >= 0 raises start again for one cycle at that busy-cycle index.
    task automatic run(input bit big, input int poke, output int cycles, output int seq_err);
        int s;
        s = big ? 3 : 1;
        @(negedge clk);
        if (big) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        cycles  = 0;
        seq_err = 0;
        while ((big ? busy3 : busy1) && cycles < 2000) begin
            if ((big ? in3 : in1) !== 4'(cycles / (s + 1))) seq_err++;
            cycles++;
            if (big) start3 = (cycles == poke); else start1 = (cycles == poke);
            @(negedge clk);
        end
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic check_results(input string name, input logic [4:0] e_err, input logic [15:0] e_fail);
        // Compares the S=1 DUT's final result outputs against expected values.
        n_chk++;
        if (done1 !== 1'b1) $display("FAIL %s done: got %b want 1", name, done1); else n_pass++;
        n_chk++;
        if (err1 !== e_err) $display("FAIL %s err_count: got %0d want %0d", name, err1, e_err); else n_pass++;
        n_chk++;
        if (fail1 !== e_fail) $display("FAIL %s fail_vec: got %h want %h", name, fail1, e_fail); else n_pass++;
        n_chk++;
        if (pass1 !== (e_err == 5'd0)) $display("FAIL %s pass: got %b want %b", name, pass1, e_err == 5'd0); else n_pass++;
    endtask

    task automatic test_reset();
        mode1 = M_SA1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({in1, busy1, done1, pass1, err1, fail1} !== 29'd0)
            $display("FAIL reset_async: got in=%h busy=%b done=%b pass=%b err=%0d fail=%h want all 0",
                     in1, busy1, done1, pass1, err1, fail1);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_chk++;
        if ({in1, busy1, done1, err1, fail1} !== 28'd0)
            $display("FAIL reset_idle: got in=%h busy=%b done=%b err=%0d fail=%h want all 0",
                     in1, busy1, done1, err1, fail1);
        else n_pass++;
    endtask

    task automatic test_ideal();
        int cyc, se;
        mode1 = M_IDEAL;
        run(1'b0, -1, cyc, se);
        n_chk++;
        if (cyc != 32) $display("FAIL ideal busy_cycles: got %0d want 32", cyc); else n_pass++;
        n_chk++;
        if (se != 0) $display("FAIL ideal clb_in_sequence: got %0d bad cycles want 0", se); else n_pass++;
        check_results("ideal", 5'd0, 16'h0000);
        n_chk++;
        if (in1 !== 4'd15) $display("FAIL ideal clb_in_hold: got %0d want 15", in1); else n_pass++;
    endtask

    task automatic test_stuck();
        int cyc, se;
        mode1 = M_SA0;
        run(1'b0, -1, cyc, se);
        check_results("stuck0", 5'd6, 16'h06E8);
        mode1 = M_SA1;
        run(1'b0, -1, cyc, se);
        check_results("stuck1", 5'd10, 16'hF917);
    endtask

    task automatic test_xnor();
        int cyc, se;
        mode1 = M_XNOR;
        run(1'b0, -1, cyc, se);
        check_results("xnor_s1", 5'd4, 16'h0F00);
        mode3 = M_XNOR;
        run(1'b1, -1, cyc, se);
        n_chk++;
        if (cyc != 64) $display("FAIL xnor_s3 busy_cycles: got %0d want 64", cyc); else n_pass++;
        n_chk++;
        if (se != 0) $display("FAIL xnor_s3 clb_in_sequence: got %0d bad cycles want 0", se); else n_pass++;
        n_chk++;
        if ({done3, pass3, err3, fail3} !== {1'b1, 1'b0, 5'd4, 16'h0F00})
            $display("FAIL xnor_s3 results: got done=%b pass=%b err=%0d fail=%h want 1 0 4 0f00",
                     done3, pass3, err3, fail3);
        else n_pass++;
    endtask

    task automatic test_random();
        int cyc, se;
        logic [15:0] m;
        for (int i = 0; i < 6; i++) begin
            inj1  = (i == 0) ? 16'h0000 : 16'($urandom);
            mode1 = M_INJ;
            run(1'b0, -1, cyc, se);
            m = exp_mask(M_INJ, inj1);
            check_results($sformatf("random%0d", i), 5'(popcount(m)), m);
        end
    endtask

    task automatic test_start_in_drive();
        int cyc, se;
        mode1 = M_XNOR;
        run(1'b0, 9, cyc, se);
        n_chk++;
        if (cyc != 32) $display("FAIL start_in_drive busy_cycles: got %0d want 32", cyc); else n_pass++;
        n_chk++;
        if (se != 0) $display("FAIL start_in_drive clb_in_sequence: got %0d bad want 0", se); else n_pass++;
        check_results("start_in_drive", 5'd4, 16'h0F00);
    endtask

    task automatic test_reset_mid_run();
        int cyc, se, w;
        mode1 = M_IDEAL;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        w = 0;
        while (in1 !== 4'd7 && w < 200) begin
            w++;
            @(negedge clk);
        end
        n_chk++;
        if (in1 !== 4'd7) $display("FAIL reset_vec7 reach: got %0d want 7", in1); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({in1, busy1, done1} !== 6'd0)
            $display("FAIL reset_vec7 async: got in=%h busy=%b done=%b want 0", in1, busy1, done1);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, -1, cyc, se);
        n_chk++;
        if (cyc != 32) $display("FAIL reset_vec7 rerun_cycles: got %0d want 32", cyc); else n_pass++;
        check_results("reset_vec7_rerun", 5'd0, 16'h0000);
    endtask

    task automatic test_start_in_done();
        int cyc, se;
        mode1 = M_SA0;
        run(1'b0, -1, cyc, se);
        check_results("done_restart_first", 5'd6, 16'h06E8);
        mode1 = M_IDEAL;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n_chk++;
        if ({busy1, done1, err1, fail1} !== {1'b1, 1'b0, 5'd0, 16'd0})
            $display("FAIL done_restart_clear: got busy=%b done=%b err=%0d fail=%h want 1 0 0 0000",
                     busy1, done1, err1, fail1);
        else n_pass++;
        cyc = 0;
        while (busy1 && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        n_chk++;
        if (cyc != 32) $display("FAIL done_restart busy_cycles: got %0d want 32", cyc); else n_pass++;
        check_results("done_restart_second", 5'd0, 16'h0000);
    endtask

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        mode1  = M_IDEAL;
        mode3  = M_IDEAL;
        inj1   = 16'd0;
        inj3   = 16'd0;
        test_reset();
        test_ideal();
        test_stuck();
        test_xnor();
        test_random();
        test_start_in_drive();
        test_reset_mid_run();
        test_start_in_done();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
